// File: rtl/arith_unit.sv
// arith_unit: registered add/sub/carry/compare/multiply unit with a persistent NZCV flag register.
// Latency: ADD/SUB/ADC/SBC/CMP/reserved take 1 cycle (start edge -> done); MUL takes WIDTH+1 cycles.
// Backpressure: none; start is accepted only while busy=0 and ignored (not sampled) during a MUL.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start, op, a, b   launch request, opcode and operands (sampled on an accepted start)
//   y, n, z, c, v     registered result and NZCV flags
//   busy, done        MUL in progress; one-cycle pulse per completed operation
module arith_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             busy,
  output logic             done
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   y_q;
  logic               n_q, z_q, c_q, v_q;
  logic               busy_q, done_q;
  logic [CW-1:0]      cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;   // multiplicand, shifted left one place per iteration
  logic [WIDTH-1:0]   mplier_q;  // multiplier, consumed LSB first

  logic               sub_op;
  logic               cin;
  logic [WIDTH-1:0]   b_opnd;
  logic [WIDTH:0]     alu_sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_v;
  logic [2*WIDTH-1:0] acc_d;

  // One WIDTH+1 bit adder serves every add/sub flavour: subtraction is a + ~b + cin.
  always_comb begin
    sub_op = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
    b_opnd = sub_op ? ~b : b;
    case (op)
      OP_ADD:         cin = 1'b0;
      OP_SUB, OP_CMP: cin = 1'b1;
      default:        cin = c_q;   // ADC/SBC chain through the current carry flag
    endcase
    alu_sum = {1'b0, a} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, cin};
    alu_res = alu_sum[WIDTH-1:0];
    if (sub_op) begin
      alu_v = (a[MSB] ^ b[MSB]) & (alu_res[MSB] ^ a[MSB]);
    end else begin
      alu_v = ~(a[MSB] ^ b[MSB]) & (alu_res[MSB] ^ a[MSB]);
    end
    acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                y_q    <= alu_res;
                n_q    <= alu_res[MSB];
                z_q    <= (alu_res == '0);
                c_q    <= alu_sum[WIDTH];
                v_q    <= alu_v;
                done_q <= 1'b1;
              end
              OP_CMP: begin
                // Flags only; the result register keeps its previous value.
                n_q    <= alu_res[MSB];
                z_q    <= (alu_res == '0);
                c_q    <= alu_sum[WIDTH];
                v_q    <= alu_v;
                done_q <= 1'b1;
              end
              OP_MUL: begin
                mcand_q  <= {{WIDTH{1'b0}}, a};
                mplier_q <= b;
                acc_q    <= '0;
                cnt_q    <= '0;
                busy_q   <= 1'b1;
                state_q  <= S_MUL;
              end
              default: begin
                // Reserved opcodes are acknowledged as a NOP.
                done_q <= 1'b1;
              end
            endcase
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Last iteration: publish from the freshly accumulated product.
            // Carry is left alone; V reports a product that does not fit WIDTH bits.
            y_q     <= acc_d[WIDTH-1:0];
            n_q     <= acc_d[MSB];
            z_q     <= (acc_d[WIDTH-1:0] == '0);
            v_q     <= (acc_d[2*WIDTH-1:WIDTH] != '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign y    = y_q;
  assign n    = n_q;
  assign z    = z_q;
  assign c    = c_q;
  assign v    = v_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_arith_unit.sv
module tb_arith_unit;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef struct packed {
    logic [31:0] y;
    logic        n;
    logic        z;
    logic        c;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;

  logic        start32, n32, z32, c32, v32, busy32, done32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, y32;

  logic        start8, n8, z8, c8, v8, busy8, done8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, y8;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;

  always #5 clk = ~clk;

  arith_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
    .y(y32), .n(n32), .z(z32), .c(c32), .v(v32), .busy(busy32), .done(done32)
  );

  arith_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .y(y8), .n(n8), .z(z8), .c(c8), .v(v8), .busy(busy8), .done(done8)
  );

  function automatic exp_t mk(input logic [31:0] yy, input logic nn, input logic zz,
                              input logic cc, input logic vv);
    return {yy, nn, zz, cc, vv};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!reset && done32) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done32: done=1 with no pending operation");
      end else begin
        e32 = q32.pop_front();
        chk("w32_y", 64'(y32), 64'(e32.y));
        chk("w32_n", 64'(n32), 64'(e32.n));
        chk("w32_z", 64'(z32), 64'(e32.z));
        chk("w32_c", 64'(c32), 64'(e32.c));
        chk("w32_v", 64'(v32), 64'(e32.v));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done8: done=1 with no pending operation");
      end else begin
        e8 = q8.pop_front();
        chk("w8_y", 64'(y8), 64'(e8.y[7:0]));
        chk("w8_n", 64'(n8), 64'(e8.n));
        chk("w8_z", 64'(z8), 64'(e8.z));
        chk("w8_c", 64'(c8), 64'(e8.c));
        chk("w8_v", 64'(v8), 64'(e8.v));
      end
    end
  end

  task automatic issue(input bit w8, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input exp_t e, input bit push);
    @(negedge clk);
    if (w8) begin
      start8 = 1'b1; op8 = o; a8 = aa[7:0]; b8 = bb[7:0];
      if (push) q8.push_back(e);
    end else begin
      start32 = 1'b1; op32 = o; a32 = aa; b32 = bb;
      if (push) q32.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start32 = 1'b0;
    start8  = 1'b0;
  endtask

  // Launch a MUL, toggle start with junk operands while busy, and measure
  // edges from the start edge (counted as 1) to the edge that raises done.
  task automatic mul_lat(input bit w8, input logic [31:0] aa, input logic [31:0] bb,
                         input exp_t e, input int lat, input string name);
    int  cnt;
    bit  seen;
    cnt  = 0;
    seen = 1'b0;
    issue(w8, OP_MUL, aa, bb, e, 1'b1);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 1) chk({name, "_busy"}, 64'(w8 ? busy8 : busy32), 64'd1);
      if (w8 ? done8 : done32) begin
        seen = 1'b1;
        break;
      end
      if (w8) begin
        start8 = cnt[0]; op8 = OP_ADD; a8 = 8'hFF; b8 = 8'h0F;
      end else begin
        start32 = cnt[0]; op32 = OP_ADD; a32 = 32'hFFFF_FFFF; b32 = 32'h0F0F_0F0F;
      end
    end
    start32 = 1'b0;
    start8  = 1'b0;
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 100 cycles, expected %0d", name, lat);
    end else begin
      chk(name, 64'(cnt), 64'(lat));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start32 = 1'b0; op32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; op8  = '0; a8  = '0; b8  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y32", 64'(y32), 64'd0);
    chk("rst_nzcv32", 64'({n32, z32, c32, v32}), 64'd0);
    chk("rst_busy_done32", 64'({busy32, done32}), 64'd0);
    chk("rst_y8_busy8", 64'({y8, busy8, done8}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset in the middle of a MUL.
    issue(1'b0, OP_SUB, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1, 0, 0, 0), 1'b1);
    issue(1'b0, OP_MUL, 32'd3, 32'd5, mk(0, 0, 0, 0, 0), 1'b0);
    @(posedge clk);
    #1;
    start32 = 1'b0;
    chk("abort_busy_before", 64'(busy32), 64'd1);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_y", 64'(y32), 64'd0);
    chk("abort_nzcv", 64'({n32, z32, c32, v32}), 64'd0);
    chk("abort_busy_done", 64'({busy32, done32}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    issue(1'b0, OP_ADD, 32'd1, 32'd1, mk(32'd2, 0, 0, 0, 0), 1'b1);
    @(posedge clk);
    #1;
    start32 = 1'b0;
    chk("add_latency1", 64'(done32), 64'd1);

    // Carry-chain and subtract boundaries.
    issue(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'h1, mk(32'h0, 0, 1, 1, 0), 1'b1);
    issue(1'b0, OP_ADC, 32'h0, 32'h0, mk(32'h1, 0, 0, 0, 0), 1'b1);
    issue(1'b0, OP_SUB, 32'h8000_0000, 32'h1, mk(32'h7FFF_FFFF, 0, 0, 1, 1), 1'b1);
    issue(1'b0, OP_SUB, 32'd5, 32'd7, mk(32'hFFFF_FFFE, 1, 0, 0, 0), 1'b1);
    issue(1'b0, OP_SBC, 32'd10, 32'd3, mk(32'd6, 0, 0, 1, 0), 1'b1);
    issue(1'b0, OP_ADD, 32'h1200, 32'h34, mk(32'h1234, 0, 0, 0, 0), 1'b1);
    issue(1'b0, OP_CMP, 32'd42, 32'd42, mk(32'h1234, 0, 1, 1, 0), 1'b1);
    idle();

    // Back-to-back single-cycle ops give consecutive done cycles.
    issue(1'b0, OP_ADD, 32'd3, 32'd4, mk(32'd7, 0, 0, 0, 0), 1'b1);
    issue(1'b0, OP_SUB, 32'd10, 32'd4, mk(32'd6, 0, 0, 1, 0), 1'b1);
    chk("b2b_done1", 64'(done32), 64'd1);
    issue(1'b0, OP_CMP, 32'd1, 32'd2, mk(32'd6, 1, 0, 0, 0), 1'b1);
    chk("b2b_done2", 64'(done32), 64'd1);
    idle();
    chk("b2b_done3", 64'(done32), 64'd1);
    @(negedge clk);
    chk("b2b_done_end", 64'(done32), 64'd0);

    // Multiply, with start pulses ignored while busy.
    mul_lat(1'b0, 32'h0001_0000, 32'h0001_0000, mk(32'h0, 0, 1, 0, 1), 33, "mul32_lat_a");
    mul_lat(1'b0, 32'd1234, 32'd5678, mk(32'd7006652, 0, 0, 0, 0), 33, "mul32_lat_b");
    repeat (5) @(negedge clk);
    chk("hold_y32", 64'(y32), 64'd7006652);
    chk("hold_done32", 64'(done32), 64'd0);

    // Narrow instance.
    issue(1'b1, OP_ADD, 32'h7F, 32'h01, mk(32'h80, 1, 0, 0, 1), 1'b1);
    idle();
    mul_lat(1'b1, 32'h10, 32'h10, mk(32'h0, 0, 1, 0, 1), 9, "mul8_lat");
    issue(1'b1, OP_SUB, 32'h80, 32'h01, mk(32'h7F, 0, 0, 1, 1), 1'b1);
    issue(1'b1, 3'b110, 32'h05, 32'h05, mk(32'h7F, 0, 0, 1, 1), 1'b1);
    issue(1'b1, 3'b111, 32'hFF, 32'hFF, mk(32'h7F, 0, 0, 1, 1), 1'b1);
    idle();
    repeat (3) @(negedge clk);
    chk("rsvd_hold_y8", 64'(y8), 64'h7F);

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q8_drained", 64'(q8.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_unit.md
Name: arith_unit

Overview:
- Parameterised, registered successor to the team's 32-bit combinational add/sub flag unit.
- Adds carry-chained ops (ADC/SBC), a flag-only compare and an iterative unsigned multiply, with a start/busy/done handshake.
- Keeps a persistent NZCV flag register.
- Sits between the datapath register file and the branch/condition logic; flags feed conditional execution.

Parameters:
WIDTH, 32, operand/result width in bits (>= 4)
CW, $clog2(WIDTH+1), multiply iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-high reset
start  input  1  launch operation; sampled only when busy=0
op  input  3  000 ADD, 001 SUB, 010 ADC, 011 SBC, 100 MUL, 101 CMP, 11x reserved
a  input  WIDTH  operand A, sampled on accepted start
b  input  WIDTH  operand B, sampled on accepted start
y  output  WIDTH  registered result
n  output  1  negative flag (result MSB)
z  output  1  zero flag
c  output  1  carry flag (carry-out; for subtraction, 1 = no borrow)
v  output  1  overflow flag
busy  output  1  high while a MUL iterates
done  output  1  one-cycle pulse when result/flags are updated

Behaviour:
- Reset (async, any state): y=0, n=z=c=v=0, busy=0, done=0, FSM to IDLE, counter cleared.
- Asserting reset mid-MUL aborts the operation; no done pulse is produced for it.
- FSM states: IDLE, MUL.
- IDLE + start + ADD/SUB/ADC/SBC/CMP: compute and register in the same edge; done=1 the next cycle; stay in IDLE.
  - Latency 1.
  - Back-to-back starts are allowed every cycle.
- Arithmetic is computed at WIDTH+1 bits:
  - ADD: a+b
  - SUB: a+~b+1
  - ADC: a+b+c
  - SBC: a+~b+c
  - c is the current flag value before the update.
- Flags for add-type ops: c = bit WIDTH of the sum; v = ~(a[MSB]^b[MSB]) & (r[MSB]^a[MSB]).
- Flags for sub-type ops: v = (a[MSB]^b[MSB]) & (r[MSB]^a[MSB]).
- n = r[MSB]; z = (r[WIDTH-1:0]==0).
- CMP: identical flags to SUB; y holds its previous value.
- IDLE + start + MUL: latch a, b; clear the accumulator; busy=1 the next cycle; go to MUL.
- MUL state:
  - Shift-add over WIDTH iterations, one multiplier bit per cycle, LSB first.
  - The accumulator is 2*WIDTH bits.
  - After the WIDTH-th iteration edge: y = low WIDTH bits; n = y[MSB]; z = (y==0); v = (high WIDTH bits != 0); c unchanged.
  - Same edge: busy=0, done=1, go to IDLE.
  - Total latency from the start edge to done: WIDTH+1 cycles.
- start while busy=1: ignored; operands and op are not sampled.
- start in IDLE with reserved op: no change to y or flags; done pulses after 1 cycle (op acknowledged as NOP).
- start deasserted: y and flags hold indefinitely.
- done is never high on two consecutive cycles for one operation.
  - With back-to-back single-cycle ops, done stays high across cycles, one cycle per accepted start.
- WIDTH-bit boundaries:
  - ADD wrap sets c and clears y.
  - SUB of equal operands sets z=1 and c=1.
  - The most-negative minus 1 sets v.

Test Plan:
1. WIDTH=32. Reset asserted mid-MUL (cycle 10) → busy, done, y and all flags go to 0 asynchronously; a following ADD 1+1 gives y=2, done 1 cycle later.
2. ADD 0xFFFFFFFF+0x00000001 → y=0, z=1, c=1, v=0, n=0. Then ADC 0x0+0x0 → y=1, c=0.
3. SUB 0x80000000-0x00000001 → y=0x7FFFFFFF, v=1, c=1, n=0. SUB 5-7 → y=0xFFFFFFFE, n=1, c=0. Then SBC 10-3 with c=0 → y=6.
4. CMP 42,42 with y previously 0x1234 → z=1, c=1, y stays 0x1234. Back-to-back ADD/SUB/CMP on consecutive cycles → three consecutive done cycles with correct per-op results.
5. MUL 0x00010000*0x00010000 → done exactly 33 cycles after the start edge; y=0, z=1, v=1; c unchanged. start pulses during busy are ignored. MUL 1234*5678 → y=7006652, v=0.
6. WIDTH=8 instance: ADD 0x7F+0x01 → y=0x80, v=1, n=1. MUL 0x10*0x10 → y=0, v=1, done at 9 cycles. Reserved op 110 → done pulse, y and flags unchanged.
